pipe_stage_skid: RTL
====================

Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed EX/MEM stage register.
- Generic pipeline stage register with a valid/ready handshake, an optional 2-entry skid buffer, synchronous flush, and bubble zeroing of control fields.
- Sits between any two pipeline stages (ID/EX, EX/MEM, MEM/WB). Lets a stage stall without a combinational ready path back through the pipe.
- Reports occupancy and a saturating stall-cycle counter to the hazard logic.

Parameters:
- DATA_W, 32: payload width; not cleared on bubbles.
- CTRL_W, 6: control-field width (load, rf_le, E, size, rw_dm style bits); forced to 0 when the output is not valid.
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
- STALL_W, 8: width of the stall counter.

Ports:
- clk  input  1  rising-edge clock.
- R  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous squash of all held entries.
- in_valid  input  1  upstream has a transfer.
- in_ready  output  1  stage can accept this cycle.
- in_data  input  DATA_W  upstream payload.
- in_ctrl  input  CTRL_W  upstream control bits.
- out_valid  output  1  stage holds a valid entry.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  DATA_W  head payload.
- out_ctrl  output  CTRL_W  head control; 0 when out_valid=0.
- occ  output  2  number of held entries, 0..2.
- stall_cnt  output  STALL_W  consecutive cycles the head has been blocked.

Behaviour:
- Internal state: main entry M (mv, md, mc) and skid entry S (sv, sd, sc). S exists only when SKID=1.
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Outputs: out_valid = mv; out_data = md; out_ctrl = mv ? mc : 0.
- Reset (R low, asynchronous): mv = sv = 0, md = sd = 0, mc = sc = 0, stall_cnt = 0.
  - Hence out_valid = 0, out_ctrl = 0, occ = 0.
  - in_ready = 1 when SKID=1; in_ready = 1 when SKID=0 (mv=0).
- Reset asserted mid-transfer discards all entries immediately, with no wait for a clock edge.
- SKID=1:
  - in_ready = ~sv, registered (no combinational path from out_ready).
  - When ~mv | out_ready: if sv, then M <= S and sv <= 0; else M <= in and mv <= in_fire.
  - When mv & ~out_ready: if in_fire, then S <= in and sv <= 1.
  - in_fire and sv=1 never occur together.
- SKID=0:
  - in_ready = ~mv | out_ready (combinational).
  - When in_ready: M <= in and mv <= in_fire.
  - occ never exceeds 1.
- Latency and throughput: 1 cycle from in_fire to out_valid on an empty stage; sustained 1 transfer/cycle with out_ready held high.
- Ordering is strict FIFO. No entry is dropped or duplicated except by flush or reset.
- Flush (sync, highest priority): next state is mv = sv = 0.
  - An in_fire in the same cycle is discarded.
  - The out_fire in the flush cycle still counts as delivered downstream.
  - stall_cnt <= 0.
  - md/sd keep their old values (don't-care); mc/sc are cleared.
- occ = mv + sv.
- stall_cnt:
  - Increments by 1 each cycle with out_valid & ~out_ready.
  - Saturates at 2^STALL_W-1 with no wrap.
  - Cleared to 0 on out_fire, on flush, or while out_valid = 0.
- Simultaneous in_fire and out_fire with only M full: M is replaced by in; occ stays 1.

Test Plan:
- Reset then idle: pulse R low for 2 cycles mid-run with occ=2 -> out_valid=0, out_ctrl=0, occ=0, stall_cnt=0 immediately; in_ready=1.
- Streaming, SKID=1: in_data 0x10,0x11,0x12,0x13 on back-to-back cycles, out_ready=1 -> same values out one cycle later, one per cycle; occ stays 1.
- Backpressure, SKID=1: send 0xA0,0xA1,0xA2 with out_ready=0 -> occ=2 after 0xA1, in_ready=0, 0xA2 held upstream; stall_cnt counts 1,2,3. Then out_ready=1 -> 0xA0,0xA1,0xA2 emitted in order; stall_cnt returns to 0.
- Flush with full stage: occ=2, assert flush together with in_valid for 0xFF -> next cycle out_valid=0, occ=0, out_ctrl=0; 0xFF never appears.
- Saturation, STALL_W=3: hold one entry with out_ready=0 for 10 cycles -> stall_cnt reaches 7 and stays at 7.
- SKID=0 combinational ready: mv=1 with out_ready toggling 0/1 -> in_ready follows out_ready in the same cycle; simultaneous in/out fire keeps occ=1 with the new data at the head.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid
//
// Generic pipeline stage register with a valid/ready handshake. It can sit
// between any two pipeline stages (ID/EX, EX/MEM, MEM/WB). With SKID=1 the
// stage holds up to two entries: a main entry M that drives the outputs and
// a skid entry S. This lets in_ready be a plain register, so no
// combinational ready path runs back through the pipe. With SKID=0 the stage
// holds one entry, and in_ready is combinational from out_ready.
//
// Control bits read as zero whenever the output is not valid, so a bubble
// can never trigger a load, a register-file write or a memory write
// downstream. The payload is not cleared on bubbles.
//
// Ports:
//   clk        rising-edge clock
//   R          asynchronous reset, active low
//   flush      synchronous squash of every held entry
//   in_valid   upstream has a transfer
//   in_ready   stage can accept this cycle
//   in_data    upstream payload            [DATA_W]
//   in_ctrl    upstream control bits       [CTRL_W]
//   out_valid  stage holds a valid entry
//   out_ready  downstream accepts this cycle
//   out_data   head payload                [DATA_W]
//   out_ctrl   head control, 0 when out_valid=0 [CTRL_W]
//   occ        number of held entries, 0..2
//   stall_cnt  saturating count of consecutive cycles the head was blocked
// ---------------------------------------------------------------------------
module pipe_stage_skid #(
    parameter int DATA_W  = 32,
    parameter int CTRL_W  = 6,
    parameter int SKID    = 1,
    parameter int STALL_W = 8
) (
    input  logic               clk,
    input  logic               R,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [CTRL_W-1:0]  in_ctrl,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [CTRL_W-1:0]  out_ctrl,
    output logic [1:0]         occ,
    output logic [STALL_W-1:0] stall_cnt
);

    logic               r_mv;
    logic [DATA_W-1:0]  r_md;
    logic [CTRL_W-1:0]  r_mc;
    logic [STALL_W-1:0] r_stall;
    logic               w_sv;
    logic               w_in_ready;
    logic               w_in_fire;
    logic               w_out_fire;

    assign w_in_fire  = in_valid & w_in_ready;
    assign w_out_fire = r_mv & out_ready;

    generate
        if (SKID != 0) begin : g_skid
            logic              r_sv;
            logic [DATA_W-1:0] r_sd;
            logic [CTRL_W-1:0] r_sc;

            // Ready depends only on the skid flag. When the skid entry is
            // full, upstream waits, so in_fire and sv=1 never coincide.
            assign w_in_ready = ~r_sv;
            assign w_sv       = r_sv;

            // If the head is free or leaving, refill it: from S first, to
            // keep FIFO order, and from the input otherwise. If the head is
            // blocked, an accepted input parks in S.
            always_ff @(posedge clk or negedge R) begin
                if (!R) begin
                    r_mv <= 1'b0;
                    r_md <= '0;
                    r_mc <= '0;
                    r_sv <= 1'b0;
                    r_sd <= '0;
                    r_sc <= '0;
                end else if (flush) begin
                    r_mv <= 1'b0;
                    r_mc <= '0;
                    r_sv <= 1'b0;
                    r_sc <= '0;
                end else if (!r_mv || out_ready) begin
                    if (r_sv) begin
                        r_md <= r_sd;
                        r_mc <= r_sc;
                        r_mv <= 1'b1;
                        r_sv <= 1'b0;
                    end else begin
                        r_md <= in_data;
                        r_mc <= in_ctrl;
                        r_mv <= w_in_fire;
                    end
                end else if (w_in_fire) begin
                    r_sd <= in_data;
                    r_sc <= in_ctrl;
                    r_sv <= 1'b1;
                end
            end
        end else begin : g_noskid
            // A single entry can accept whenever it is empty or draining
            // this cycle, so ready follows out_ready combinationally.
            assign w_in_ready = ~r_mv | out_ready;
            assign w_sv       = 1'b0;

            always_ff @(posedge clk or negedge R) begin
                if (!R) begin
                    r_mv <= 1'b0;
                    r_md <= '0;
                    r_mc <= '0;
                end else if (flush) begin
                    r_mv <= 1'b0;
                    r_mc <= '0;
                end else if (w_in_ready) begin
                    r_md <= in_data;
                    r_mc <= in_ctrl;
                    r_mv <= w_in_fire;
                end
            end
        end
    endgenerate

    // Counts only while a valid head is being refused. The count holds at
    // all-ones instead of wrapping, so a long stall never reads as a short
    // one.
    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            r_stall <= '0;
        end else if (flush || !r_mv || w_out_fire) begin
            r_stall <= '0;
        end else if (r_stall != {STALL_W{1'b1}}) begin
            r_stall <= r_stall + STALL_W'(1);
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_mv;
    assign out_data  = r_md;
    assign out_ctrl  = r_mv ? r_mc : '0;
    assign occ       = {1'b0, r_mv} + {1'b0, w_sv};
    assign stall_cnt = r_stall;

endmodule
